// File: rtl/linear_solver_pkg.sv
// Shared definitions for the trilateration solver: FSM state codes and the
// 3x3 determinant helper used by the determinant unit.
package linear_solver_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LOAD = 4'd1,
        DIFF = 4'd2,
        RHS  = 4'd3,
        DET  = 4'd4,
        NUMX = 4'd5,
        NUMY = 4'd6,
        NUMZ = 4'd7,
        DIV  = 4'd8,
        DONE = 4'd9
    } state_t;

    // Row-major 3x3 determinant by cofactor expansion along the first row.
    function automatic real det3(
        input real m00, input real m01, input real m02,
        input real m10, input real m11, input real m12,
        input real m20, input real m21, input real m22
    );
        return m00 * (m11 * m22 - m12 * m21)
             - m01 * (m10 * m22 - m12 * m20)
             + m02 * (m10 * m21 - m11 * m20);
    endfunction

endpackage

// File: rtl/linear_solver_det.sv
// Combinational 3x3 determinant with an optional column replaced by the
// right-hand side (sel: 0 none, 1 column a, 2 column b, 3 column c).
module det3_unit
    import linear_solver_pkg::*;
(
    input  logic [1:0] sel,
    input  real        a2,
    input  real        a3,
    input  real        a4,
    input  real        b2,
    input  real        b3,
    input  real        b4,
    input  real        c2,
    input  real        c3,
    input  real        c4,
    input  real        d2,
    input  real        d3,
    input  real        d4,
    output real        det
);

    real k0_2, k0_3, k0_4;
    real k1_2, k1_3, k1_4;
    real k2_2, k2_3, k2_4;

    always_comb begin
        k0_2 = (sel == 2'd1) ? d2 : a2;
        k0_3 = (sel == 2'd1) ? d3 : a3;
        k0_4 = (sel == 2'd1) ? d4 : a4;
        k1_2 = (sel == 2'd2) ? d2 : b2;
        k1_3 = (sel == 2'd2) ? d3 : b3;
        k1_4 = (sel == 2'd2) ? d4 : b4;
        k2_2 = (sel == 2'd3) ? d2 : c2;
        k2_3 = (sel == 2'd3) ? d3 : c3;
        k2_4 = (sel == 2'd3) ? d4 : c4;
        det  = det3(k0_2, k1_2, k2_2,
                    k0_3, k1_3, k2_3,
                    k0_4, k1_4, k2_4);
    end

endmodule

// File: rtl/linear_solver.sv
// Trilateration solver: linearises four sphere equations against sphere 1 and
// solves the resulting 3x3 system by Cramer's rule, one FSM step per clock.
module linear_solver
    import linear_solver_pkg::*;
(
    input  logic       clk,
    input  real        x1,
    input  real        x2,
    input  real        x3,
    input  real        x4,
    input  real        y1,
    input  real        y2,
    input  real        y3,
    input  real        y4,
    input  real        z1,
    input  real        z2,
    input  real        z3,
    input  real        z4,
    input  real        r1,
    input  real        r2,
    input  real        r3,
    input  real        r4,
    output real        c1,
    output real        c2,
    output real        c3,
    output logic       done,
    output logic [3:0] state,
    input  logic       en,
    input  logic       rst_n
);

    // Handshake: en is a level request seen only in IDLE and DONE. A solve starts
    // when en=1 in IDLE; done stays high in DONE until en drops, then back to IDLE.
    state_t state_q = IDLE;
    state_t state_d;
    real    c1_q = 0.0;
    real    c2_q = 0.0;
    real    c3_q = 0.0;

    real xr [1:4];
    real yr [1:4];
    real zr [1:4];
    real rr [1:4];
    real a_q [2:4];
    real b_q [2:4];
    real c_q [2:4];
    real d_q [2:4];
    real det_q, dx_q, dy_q, dz_q;
    real det_out;
    logic [1:0] sel;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        sel     = 2'd0;
        case (state_q)
            IDLE: state_d = en ? LOAD : IDLE;
            LOAD: state_d = DIFF;
            DIFF: state_d = RHS;
            RHS:  state_d = DET;
            DET:  state_d = NUMX;
            NUMX: begin state_d = NUMY; sel = 2'd1; end
            NUMY: begin state_d = NUMZ; sel = 2'd2; end
            NUMZ: begin state_d = DIV;  sel = 2'd3; end
            DIV:  state_d = DONE;
            DONE: state_d = en ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    det3_unit u_det (
        .sel (sel),
        .a2  (a_q[2]), .a3 (a_q[3]), .a4 (a_q[4]),
        .b2  (b_q[2]), .b3 (b_q[3]), .b4 (b_q[4]),
        .c2  (c_q[2]), .c3 (c_q[3]), .c4 (c_q[4]),
        .d2  (d_q[2]), .d3 (d_q[3]), .d4 (d_q[4]),
        .det (det_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c1_q <= 0.0;
            c2_q <= 0.0;
            c3_q <= 0.0;
        end else begin
            case (state_q)
                LOAD: begin
                    xr[1] <= x1; xr[2] <= x2; xr[3] <= x3; xr[4] <= x4;
                    yr[1] <= y1; yr[2] <= y2; yr[3] <= y3; yr[4] <= y4;
                    zr[1] <= z1; zr[2] <= z2; zr[3] <= z3; zr[4] <= z4;
                    rr[1] <= r1; rr[2] <= r2; rr[3] <= r3; rr[4] <= r4;
                end
                DIFF: begin
                    for (int i = 2; i <= 4; i++) begin
                        a_q[i] <= 2.0 * (xr[i] - xr[1]);
                        b_q[i] <= 2.0 * (yr[i] - yr[1]);
                        c_q[i] <= 2.0 * (zr[i] - zr[1]);
                    end
                end
                RHS: begin
                    for (int i = 2; i <= 4; i++) begin
                        d_q[i] <= rr[1] * rr[1] - rr[i] * rr[i]
                                + xr[i] * xr[i] - xr[1] * xr[1]
                                + yr[i] * yr[i] - yr[1] * yr[1]
                                + zr[i] * zr[i] - zr[1] * zr[1];
                    end
                end
                DET:  det_q <= det_out;
                NUMX: dx_q  <= det_out;
                NUMY: dy_q  <= det_out;
                NUMZ: dz_q  <= det_out;
                DIV: begin
                    // Coplanar or degenerate geometry has no unique fix; report origin.
                    if (det_q == 0.0) begin
                        c1_q <= 0.0;
                        c2_q <= 0.0;
                        c3_q <= 0.0;
                    end else begin
                        c1_q <= dx_q / det_q;
                        c2_q <= dy_q / det_q;
                        c3_q <= dz_q / det_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign c1    = c1_q;
    assign c2    = c2_q;
    assign c3    = c3_q;
    assign done  = (state_q == DONE);
    assign state = state_q;

endmodule

// File: tb/tb_linear_solver.sv
// Directed bench for linear_solver: nominal, coplanar, real-world scale,
// mid-solve reset and en request handling.
module tb_linear_solver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    real        x1, x2, x3, x4, y1, y2, y3, y4, z1, z2, z3, z4, r1, r2, r3, r4;
    real        c1, c2, c3;
    logic       done;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q [$];

    linear_solver dut (
        .clk (clk),
        .x1 (x1), .x2 (x2), .x3 (x3), .x4 (x4),
        .y1 (y1), .y2 (y2), .y3 (y3), .y4 (y4),
        .z1 (z1), .z2 (z2), .z3 (z3), .z4 (z4),
        .r1 (r1), .r2 (r2), .r3 (r3), .r4 (r4),
        .c1 (c1), .c2 (c2), .c3 (c3),
        .done (done),
        .state (state),
        .en (en),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input real got, input real exp, input real tol);
        real diff;
        n_checks++;
        diff = got - exp;
        if (diff < 0.0) diff = -diff;
        if (diff > tol)
            $display("FAIL %s: got %g expected %g (tol %g)", tag, got, exp, tol);
        else
            n_pass++;
    endtask

    task automatic set_pts(
        input real ax, input real ay, input real az,
        input real bx, input real by, input real bz,
        input real cx, input real cy, input real cz,
        input real dx, input real dy, input real dz
    );
        x1 = ax; y1 = ay; z1 = az;
        x2 = bx; y2 = by; z2 = bz;
        x3 = cx; y3 = cy; z3 = cz;
        x4 = dx; y4 = dy; z4 = dz;
    endtask

    task automatic set_r(input real a, input real b, input real c, input real d);
        r1 = a; r2 = b; r3 = c; r4 = d;
    endtask

    task automatic check_c(input string tag, input real e1, input real e2, input real e3, input real tol);
        check({tag, "_c1"}, c1, e1, tol);
        check({tag, "_c2"}, c2, e2, tol);
        check({tag, "_c3"}, c3, e3, tol);
    endtask

    task automatic check_st(input string tag, input int exp_state, input int exp_done);
        check({tag, "_state"}, real'(state), real'(exp_state), 0.0);
        check({tag, "_done"},  real'(done),  real'(exp_done),  0.0);
    endtask

    // Residual of one linearised equation i (2..4) against the current outputs.
    task automatic check_res(input string tag, input real xa, input real ya, input real za, input real ra,
                             input real xi, input real yi, input real zi, input real ri);
        real a, b, c, d, res, bound;
        a = 2.0 * (xi - xa);
        b = 2.0 * (yi - ya);
        c = 2.0 * (zi - za);
        d = ra * ra - ri * ri + xi * xi - xa * xa + yi * yi - ya * ya + zi * zi - za * za;
        res = a * c1 + b * c2 + c * c3 - d;
        bound = (d < 0.0) ? -d : d;
        check(tag, res, 0.0, 1.0e-6 * bound);
    endtask

    initial begin
        int n;

        set_pts(0.0, 0.0, 0.0, 10.0, 0.0, 0.0, 0.0, 10.0, 0.0, 0.0, 0.0, 10.0);
        set_r($sqrt(14.0), $sqrt(94.0), $sqrt(74.0), $sqrt(54.0));

        // Power-up and reset values
        #1;
        check_st("pwrup", 0, 0);
        check_c("pwrup", 0.0, 0.0, 0.0, 0.0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check_st("idle_en0", 0, 0);

        // Nominal solve, receiver at (1,2,3); state walks 1..9
        en = 1'b1;
        for (int s = 1; s <= 9; s++) exp_q.push_back(4'(s));
        while (exp_q.size() > 0) begin
            tick(1);
            check("seq", real'(state), real'(exp_q.pop_front()), 0.0);
        end
        check_st("nominal", 9, 1);
        check_c("nominal", 1.0, 2.0, 3.0, 1.0e-9);

        // Reset in NUMX abandons the solve and clears outputs
        en = 1'b0;
        tick(1);
        check_st("back_idle", 0, 0);
        en = 1'b1;
        tick(5);
        check_st("mid_numx", 5, 0);
        rst_n = 1'b0;
        tick(1);
        check_st("mid_rst", 0, 0);
        check_c("mid_rst", 0.0, 0.0, 0.0, 0.0);
        rst_n = 1'b1;
        tick(9);
        check_st("post_rst", 9, 1);
        check_c("post_rst", 1.0, 2.0, 3.0, 1.0e-9);

        // Real-world scale, bounded wait for done
        en = 1'b0;
        tick(1);
        x1 = 2088202.299;   x2 = 11092568.240;  x3 = 35606984.591; x4 = 3966929.048;
        y1 = -11757191.370; y2 = -14198201.090; y3 = 94447027.237; y4 = 7362851.831;
        z1 = 25391471.881;  z2 = 21471165.950;  z3 = 9101378.572;  z4 = 26388447.172;
        set_r(23204698.51, 21585835.37, 31364260.01, 24966798.73);
        en = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 16) begin
            tick(1);
            n++;
        end
        check("gps_done", real'(done), 1.0, 0.0);
        check_res("gps_res2", x1, y1, z1, r1, x2, y2, z2, r2);
        check_res("gps_res3", x1, y1, z1, r1, x3, y3, z3, r3);
        check_res("gps_res4", x1, y1, z1, r1, x4, y4, z4, r4);

        // Coplanar points give D = 0 and a zero result
        en = 1'b0;
        tick(1);
        set_pts(0.0, 0.0, 0.0, 10.0, 0.0, 0.0, 0.0, 10.0, 0.0, 10.0, 10.0, 0.0);
        set_r(5.0, 6.0, 7.0, 8.0);
        en = 1'b1;
        tick(9);
        check_st("coplanar", 9, 1);
        check_c("coplanar", 0.0, 0.0, 0.0, 0.0);

        // en handling: idle while low, hold in DONE while high, restart on toggle
        en = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check_st("en_low", 0, 0);
        set_pts(0.0, 0.0, 0.0, 10.0, 0.0, 0.0, 0.0, 10.0, 0.0, 0.0, 0.0, 10.0);
        set_r($sqrt(14.0), $sqrt(94.0), $sqrt(74.0), $sqrt(54.0));
        en = 1'b1;
        tick(9);
        check_st("hold0", 9, 1);
        tick(4);
        check_st("hold1", 9, 1);
        check_c("hold1", 1.0, 2.0, 3.0, 1.0e-9);
        // Receiver at (2,-1,4): inputs change while held in DONE
        set_r($sqrt(21.0), 9.0, $sqrt(141.0), $sqrt(41.0));
        tick(2);
        check_st("hold2", 9, 1);
        check_c("hold2", 1.0, 2.0, 3.0, 1.0e-9);
        en = 1'b0;
        tick(1);
        check_st("toggle_idle", 0, 0);
        en = 1'b1;
        tick(9);
        check_st("resolve", 9, 1);
        check_c("resolve", 2.0, -1.0, 4.0, 1.0e-9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
